// File: rtl/vga_text_buffer_pkg.sv
// Shared constants, control codes, FSM state encodings and row type for the VGA text buffer.
package vga_text_pkg;

    localparam int DEF_ROW_CNT  = 3;
    localparam int DEF_ROW_SIZE = 10;
    localparam int DEF_CODE_W   = 8;

    localparam logic [DEF_CODE_W-1:0] CODE_NUL       = 8'h00;
    localparam logic [DEF_CODE_W-1:0] CODE_NEWLINE   = 8'hFD;
    localparam logic [DEF_CODE_W-1:0] CODE_BACKSPACE = 8'hFE;

    localparam logic [0:0] S_ACCEPT = 1'b0;
    localparam logic [0:0] S_SCROLL = 1'b1;

    typedef struct packed {
        logic [DEF_ROW_SIZE-1:0][DEF_CODE_W-1:0] letters;
        logic [3:0]                              cnt;
    } row_t;

    function automatic logic is_printable(input logic [DEF_CODE_W-1:0] code);
        return (code != CODE_NUL) && (code != CODE_NEWLINE) && (code != CODE_BACKSPACE);
    endfunction

endpackage

// File: rtl/vga_text_buffer_if.sv
// Valid/ready handshake carrying one glyph or control code into the text buffer.
interface vga_text_buffer_if
    import vga_text_pkg::*;
#(
    parameter int CODE_W = DEF_CODE_W
) ();

    logic              valid;
    logic              ready;
    logic [CODE_W-1:0] code;

    modport master (output valid, output code, input ready);
    modport slave  (input valid, input code, output ready);

endinterface

// File: rtl/vga_text_buffer.sv
// Text grid with cursor, wrap, newline, backspace, clear and scroll-up feeding the VGA display.
// Define VGA_TEXT_VSYNC_LATCH_EN to present the grid through shadow registers updated on i_frame_start.
module vga_text_buffer
    import vga_text_pkg::*;
#(
    parameter int ROW_CNT  = DEF_ROW_CNT,
    parameter int ROW_SIZE = DEF_ROW_SIZE,
    parameter int CODE_W   = DEF_CODE_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    vga_text_buffer_if.slave    bus,
    input  logic                i_clear,
    input  logic                i_frame_start,
    output logic [3:0]          o_letter_cnt [ROW_CNT],
    output logic [CODE_W-1:0]   o_letters    [ROW_CNT][ROW_SIZE],
    output logic                o_start
);

    localparam int               ROW_W    = (ROW_CNT > 1) ? $clog2(ROW_CNT) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROW_CNT - 1);
    localparam logic [3:0]       FULL_COL = 4'(ROW_SIZE);

    typedef struct packed {
        logic [ROW_SIZE-1:0][CODE_W-1:0] letters;
        logic [3:0]                      cnt;
    } grid_row_t;

    grid_row_t         rows [ROW_CNT];
    logic [0:0]        state;
    logic [ROW_W-1:0]  cur_row;
    logic [3:0]        cur_col;
    logic [ROW_W-1:0]  scroll_idx;
    logic              pending_vld;
    logic [CODE_W-1:0] pending_code;
    logic              started;

    logic              take;
    logic [ROW_W-1:0]  next_row;
    logic [ROW_W-1:0]  prev_row;
    logic [ROW_W-1:0]  scroll_src;
    logic [3:0]        prev_cnt;

    // Ready is withheld for the whole cycle a clear is requested so no code slips in alongside it.
    assign bus.ready  = started && (state == S_ACCEPT) && !i_clear;
    assign take       = bus.valid && bus.ready;
    assign o_start    = started;
    assign next_row   = cur_row + 1'b1;
    assign prev_row   = cur_row - 1'b1;
    assign scroll_src = scroll_idx + 1'b1;
    assign prev_cnt   = rows[prev_row].cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < ROW_CNT; r++) begin
                rows[r] <= '0;
            end
            state        <= S_ACCEPT;
            cur_row      <= '0;
            cur_col      <= '0;
            scroll_idx   <= '0;
            pending_vld  <= 1'b0;
            pending_code <= '0;
            started      <= 1'b0;
        end else begin
            started <= 1'b1;
            if (i_clear) begin
                for (int r = 0; r < ROW_CNT; r++) begin
                    rows[r] <= '0;
                end
                state       <= S_ACCEPT;
                cur_row     <= '0;
                cur_col     <= '0;
                scroll_idx  <= '0;
                pending_vld <= 1'b0;
            end else if (state == S_SCROLL) begin
                // One row moves up per cycle; the final cycle blanks the bottom row and drops in the pending glyph.
                if (scroll_idx != LAST_ROW) begin
                    rows[scroll_idx] <= rows[scroll_src];
                    scroll_idx       <= scroll_src;
                end else begin
                    rows[LAST_ROW] <= '0;
                    if (pending_vld) begin
                        rows[LAST_ROW].letters[0] <= pending_code;
                        rows[LAST_ROW].cnt        <= 4'd1;
                        cur_col                   <= 4'd1;
                    end else begin
                        cur_col <= '0;
                    end
                    pending_vld <= 1'b0;
                    scroll_idx  <= '0;
                    state       <= S_ACCEPT;
                end
            end else if (take) begin
                if (bus.code == CODE_NEWLINE) begin
                    if (cur_row != LAST_ROW) begin
                        cur_row <= next_row;
                        cur_col <= '0;
                    end else begin
                        pending_vld <= 1'b0;
                        scroll_idx  <= '0;
                        state       <= S_SCROLL;
                    end
                end else if (bus.code == CODE_BACKSPACE) begin
                    if (cur_col != '0) begin
                        rows[cur_row].letters[cur_col - 4'd1] <= '0;
                        rows[cur_row].cnt                     <= cur_col - 4'd1;
                        cur_col                               <= cur_col - 4'd1;
                    end else if (cur_row != '0) begin
                        cur_row <= prev_row;
                        if (prev_cnt != '0) begin
                            rows[prev_row].letters[prev_cnt - 4'd1] <= '0;
                            rows[prev_row].cnt                      <= prev_cnt - 4'd1;
                            cur_col                                 <= prev_cnt - 4'd1;
                        end else begin
                            cur_col <= '0;
                        end
                    end
                end else if (is_printable(bus.code)) begin
                    if (cur_col != FULL_COL) begin
                        rows[cur_row].letters[cur_col] <= bus.code;
                        rows[cur_row].cnt              <= cur_col + 4'd1;
                        cur_col                        <= cur_col + 4'd1;
                    end else if (cur_row != LAST_ROW) begin
                        rows[next_row].letters[0] <= bus.code;
                        rows[next_row].cnt        <= 4'd1;
                        cur_row                   <= next_row;
                        cur_col                   <= 4'd1;
                    end else begin
                        pending_code <= bus.code;
                        pending_vld  <= 1'b1;
                        scroll_idx   <= '0;
                        state        <= S_SCROLL;
                    end
                end
            end
        end
    end

`ifdef VGA_TEXT_VSYNC_LATCH_EN
    grid_row_t shadow [ROW_CNT];

    // A half-scrolled grid is never published: frame starts during a scroll leave the shadow as it was.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < ROW_CNT; r++) begin
                shadow[r] <= '0;
            end
        end else if (i_frame_start && (state != S_SCROLL)) begin
            for (int r = 0; r < ROW_CNT; r++) begin
                shadow[r] <= rows[r];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < ROW_CNT; r++) begin
            o_letter_cnt[r] = shadow[r].cnt;
            for (int c = 0; c < ROW_SIZE; c++) begin
                o_letters[r][c] = shadow[r].letters[c];
            end
        end
    end
`else
    logic unused_frame_start;
    assign unused_frame_start = i_frame_start;

    always_comb begin
        for (int r = 0; r < ROW_CNT; r++) begin
            o_letter_cnt[r] = rows[r].cnt;
            for (int c = 0; c < ROW_SIZE; c++) begin
                o_letters[r][c] = rows[r].letters[c];
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_text_buffer.sv
// Randomized self-checking bench for vga_text_buffer against an atomic text-editor model of the grid.
`timescale 1ns/1ps
module tb_vga_text_buffer;
    import vga_text_pkg::*;

    localparam int RC = 3;
    localparam int RS = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       frame_start;
    logic [3:0] letter_cnt [RC];
    logic [7:0] letters    [RC][RS];
    logic       start;

    vga_text_buffer_if #(.CODE_W(8)) bus ();

    vga_text_buffer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .bus           (bus),
        .i_clear       (clear),
        .i_frame_start (frame_start),
        .o_letter_cnt  (letter_cnt),
        .o_letters     (letters),
        .o_start       (start)
    );

    always #5 clk = ~clk;

    // Model: edits apply atomically; a scroll just marks the buffer busy for RC cycles.
    int m_grid [RC][RS];
    int m_cnt  [RC];
    int m_sh_grid [RC][RS];
    int m_sh_cnt  [RC];
    int m_row, m_col, m_busy;
    bit m_started;

    int   checks = 0;
    int   fails  = 0;
    logic last_ready;

    function automatic void modelClear();
        for (int r = 0; r < RC; r++) begin
            m_cnt[r] = 0;
            for (int c = 0; c < RS; c++) m_grid[r][c] = 0;
        end
        m_row  = 0;
        m_col  = 0;
        m_busy = 0;
    endfunction

    function automatic void modelScroll(input int code, input bit has_code);
        for (int r = 0; r < RC - 1; r++) begin
            m_cnt[r] = m_cnt[r + 1];
            for (int c = 0; c < RS; c++) m_grid[r][c] = m_grid[r + 1][c];
        end
        m_cnt[RC - 1] = 0;
        for (int c = 0; c < RS; c++) m_grid[RC - 1][c] = 0;
        m_row = RC - 1;
        if (has_code) begin
            m_grid[RC - 1][0] = code;
            m_cnt[RC - 1]     = 1;
            m_col             = 1;
        end else begin
            m_col = 0;
        end
        m_busy = RC;
    endfunction

    function automatic void modelApply(input int code);
        if (code == int'(CODE_NEWLINE)) begin
            if (m_row < RC - 1) begin
                m_row++;
                m_col = 0;
            end else begin
                modelScroll(0, 1'b0);
            end
        end else if (code == int'(CODE_BACKSPACE)) begin
            if (m_col > 0) begin
                m_col--;
                m_grid[m_row][m_col] = 0;
                m_cnt[m_row]--;
            end else if (m_row > 0) begin
                m_row--;
                if (m_cnt[m_row] > 0) begin
                    m_cnt[m_row]--;
                    m_grid[m_row][m_cnt[m_row]] = 0;
                    m_col = m_cnt[m_row];
                end else begin
                    m_col = 0;
                end
            end
        end else if (code != int'(CODE_NUL)) begin
            if (m_col < RS) begin
                m_grid[m_row][m_col] = code;
                m_col++;
                m_cnt[m_row] = m_col;
            end else if (m_row < RC - 1) begin
                m_row++;
                m_grid[m_row][0] = code;
                m_cnt[m_row]     = 1;
                m_col            = 1;
            end else begin
                modelScroll(code, 1'b1);
            end
        end
    endfunction

    function automatic int expLetter(input int r, input int c);
`ifdef VGA_TEXT_VSYNC_LATCH_EN
        return m_sh_grid[r][c];
`else
        return m_grid[r][c];
`endif
    endfunction

    function automatic int expCnt(input int r);
`ifdef VGA_TEXT_VSYNC_LATCH_EN
        return m_sh_cnt[r];
`else
        return m_cnt[r];
`endif
    endfunction

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        bit meaningful;
        int er, ec, ea, ee;
        checkInt("start", int'(start), int'(m_started));
`ifdef VGA_TEXT_VSYNC_LATCH_EN
        meaningful = 1'b1;
`else
        meaningful = (m_busy == 0);
`endif
        if (meaningful) begin
            er = -1; ec = -1; ea = 0; ee = 0;
            checks++;
            for (int r = 0; r < RC; r++)
                for (int c = 0; c < RS; c++)
                    if (er < 0 && int'(letters[r][c]) != expLetter(r, c)) begin
                        er = r; ec = c; ea = int'(letters[r][c]); ee = expLetter(r, c);
                    end
            if (er >= 0) begin
                fails++;
                $display("[TB] FAIL grid[%0d][%0d] actual=%0d required=%0d at %0t", er, ec, ea, ee, $time);
            end
            er = -1;
            checks++;
            for (int r = 0; r < RC; r++)
                if (er < 0 && int'(letter_cnt[r]) != expCnt(r)) begin
                    er = r; ea = int'(letter_cnt[r]); ee = expCnt(r);
                end
            if (er >= 0) begin
                fails++;
                $display("[TB] FAIL letter_cnt[%0d] actual=%0d required=%0d at %0t", er, ea, ee, $time);
            end
        end
    endtask

    // One clock cycle: drive at negedge, check ready, step the model at posedge, check outputs at next negedge.
    task automatic applyStimulus(input bit v, input int c, input bit clr, input bit fs, output bit accepted);
        bit exp_ready;
        bus.valid   = v;
        bus.code    = 8'(c);
        clear       = clr;
        frame_start = fs;
        #1;
        exp_ready  = m_started && (m_busy == 0) && !clr;
        last_ready = bus.ready;
        checkInt("ready", int'(bus.ready), int'(exp_ready));
        @(posedge clk);
        if (fs && m_busy == 0) begin
            for (int r = 0; r < RC; r++) begin
                m_sh_cnt[r] = m_cnt[r];
                for (int k = 0; k < RS; k++) m_sh_grid[r][k] = m_grid[r][k];
            end
        end
        accepted = v && exp_ready;
        if (clr)             modelClear();
        else if (m_busy > 0) m_busy--;
        else if (accepted)   modelApply(c);
        m_started = 1'b1;
        @(negedge clk);
        bus.valid   = 1'b0;
        clear       = 1'b0;
        frame_start = 1'b0;
        checkOutput();
    endtask

    task automatic sendCode(input int c);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) applyStimulus(1'b1, c, 1'b0, 1'b0, acc);
        checks++;
        if (!acc) begin
            fails++;
            $display("[TB] FAIL send_timeout code=%0d actual=not_accepted required=accepted", c);
        end
    endtask

    task automatic idleCycle();
        bit dummy;
        applyStimulus(1'b0, 0, 1'b0, 1'b0, dummy);
    endtask

    task automatic frameSync();
        bit dummy;
        applyStimulus(1'b0, 0, 1'b0, 1'b1, dummy);
    endtask

    task automatic clearGrid();
        bit dummy;
        applyStimulus(1'b0, 0, 1'b1, 1'b0, dummy);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  low;
        int  c;
        int  sel;
        bit  dummy;

        rst = 1'b1; bus.valid = 1'b0; bus.code = '0; clear = 1'b0; frame_start = 1'b0;
        modelClear();
        m_started = 1'b0;
        for (int r = 0; r < RC; r++) begin
            m_sh_cnt[r] = 0;
            for (int k = 0; k < RS; k++) m_sh_grid[r][k] = 0;
        end

        repeat (3) @(negedge clk);
        checkInt("reset_start", int'(start), 0);
        checkInt("reset_ready", int'(bus.ready), 0);
        checkInt("reset_cnt0", int'(letter_cnt[0]), 0);
        checkInt("reset_letter_2_9", int'(letters[2][9]), 0);
        rst = 1'b0;
        #1 checkInt("ready_before_first_edge", int'(bus.ready), 0);
        idleCycle();
        checkInt("start_after_first_edge", int'(start), 1);

        sendCode(37); sendCode(10); sendCode(15);
        frameSync();
        checkInt("t1_letter_0_0", int'(letters[0][0]), 37);
        checkInt("t1_letter_0_1", int'(letters[0][1]), 10);
        checkInt("t1_letter_0_2", int'(letters[0][2]), 15);
        checkInt("t1_cnt0", int'(letter_cnt[0]), 3);
        checkInt("t1_ready", int'(last_ready), 1);

        clearGrid();
        for (int i = 1; i <= 11; i++) sendCode(i);
        frameSync();
        checkInt("t2_cnt0", int'(letter_cnt[0]), 10);
        checkInt("t2_letter_0_9", int'(letters[0][9]), 10);
        checkInt("t2_letter_1_0", int'(letters[1][0]), 11);
        checkInt("t2_cnt1", int'(letter_cnt[1]), 1);

        clearGrid();
        for (int i = 1; i <= 30; i++) sendCode(i);
        sendCode(99);
        low = 0;
        for (int i = 0; i < 6; i++) begin
            idleCycle();
            if (!last_ready) low++;
        end
        checkInt("t3_ready_low_cycles", low, 3);
        frameSync();
        checkInt("t3_letter_0_0", int'(letters[0][0]), 11);
        checkInt("t3_letter_0_9", int'(letters[0][9]), 20);
        checkInt("t3_letter_1_0", int'(letters[1][0]), 21);
        checkInt("t3_letter_2_0", int'(letters[2][0]), 99);
        checkInt("t3_letter_2_1", int'(letters[2][1]), 0);
        checkInt("t3_cnt2", int'(letter_cnt[2]), 1);

        clearGrid();
        for (int i = 1; i <= 11; i++) sendCode(i);
        sendCode(int'(CODE_BACKSPACE));
        sendCode(int'(CODE_BACKSPACE));
        frameSync();
        checkInt("t4_letter_0_9", int'(letters[0][9]), 0);
        checkInt("t4_cnt0", int'(letter_cnt[0]), 9);
        checkInt("t4_cnt1", int'(letter_cnt[1]), 0);
        clearGrid();
        sendCode(int'(CODE_BACKSPACE));
        sendCode(7);
        frameSync();
        checkInt("t4_origin_letter", int'(letters[0][0]), 7);
        checkInt("t4_origin_cnt0", int'(letter_cnt[0]), 1);

        clearGrid();
        for (int i = 1; i <= 30; i++) sendCode(i);
        sendCode(99);
        idleCycle();
        applyStimulus(1'b1, 42, 1'b1, 1'b0, dummy);
        frameSync();
        checkInt("t5_cnt0", int'(letter_cnt[0]), 0);
        checkInt("t5_cnt2", int'(letter_cnt[2]), 0);
        checkInt("t5_ready", int'(last_ready), 1);
        sendCode(77);
        frameSync();
        checkInt("t5_letter_0_0", int'(letters[0][0]), 77);
        checkInt("t5_cnt0_after", int'(letter_cnt[0]), 1);

`ifdef VGA_TEXT_VSYNC_LATCH_EN
        clearGrid();
        frameSync();
        sendCode(5);
        idleCycle();
        idleCycle();
        checkInt("t6_held_letter", int'(letters[0][0]), 0);
        frameSync();
        checkInt("t6_latched_letter", int'(letters[0][0]), 5);
`endif

        clearGrid();
        for (int n = 0; n < 800; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 60)      c = int'($urandom_range(1, 252));
            else if (sel < 75) c = int'(CODE_NEWLINE);
            else if (sel < 95) c = int'(CODE_BACKSPACE);
            else if (sel < 98) c = int'(CODE_NUL);
            else               c = 255;
            applyStimulus($urandom_range(0, 9) < 7, c, $urandom_range(0, 199) == 0,
                          $urandom_range(0, 7) == 0, dummy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
